// File: rtl/ysyx_25040111_wbu.sv
// Writeback unit: registers ALU results or extracted load data into a single-cycle
// register-file write, and pulses commit (plus ld_err for faulted loads) per instruction.
module ysyx_25040111_wbu #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_rd_wen,
  input  logic               in_is_load,
  input  logic [2:0]         in_funct3,
  input  logic [1:0]         in_addr_lo,
  input  logic [XLEN-1:0]    in_alu_res,
  input  logic               mem_rvalid,
  output logic               mem_rready,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic               mem_rerr,
  output logic               rf_wen,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               commit,
  output logic               ld_err,
  output logic               dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE (after reset release); mem_rready only in WAIT_MEM.
  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_alive;
  logic [RADDR_W-1:0]   r_rd;
  logic                 r_rd_wen;
  logic [2:0]           r_funct3;
  logic [1:0]           r_addr_lo;

  logic                 w_accept;
  logic                 w_resp;
  logic [XLEN-1:0]      w_shifted;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [XLEN-1:0]      w_ld_data;

  // r_alive keeps in_ready low until the first edge after reset release.
  assign in_ready   = r_alive && (r_state == S_IDLE);
  assign mem_rready = (r_state == S_WAIT_MEM);
  assign w_accept   = in_valid && in_ready;
  assign w_resp     = mem_rvalid && mem_rready;
  assign dbg_state  = r_state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept && in_is_load) w_state_nxt = S_WAIT_MEM;
      S_WAIT_MEM: if (mem_rvalid) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Load extraction; halves are picked by addr_lo[1] only.
  always_comb begin
    w_shifted = mem_rdata >> {r_addr_lo, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_ld_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_ld_data = {{(XLEN-16){1'b0}}, w_half};
      default: w_ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd      <= '0;
      r_rd_wen  <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr_lo <= 2'b00;
    end else if (w_accept && in_is_load) begin
      r_rd      <= in_rd;
      r_rd_wen  <= in_rd_wen;
      r_funct3  <= in_funct3;
      r_addr_lo <= in_addr_lo;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      commit   <= 1'b0;
      ld_err   <= 1'b0;
    end else begin
      rf_wen <= 1'b0;
      commit <= 1'b0;
      ld_err <= 1'b0;
      if (w_accept && !in_is_load) begin
        rf_wen   <= in_rd_wen && (in_rd != '0);
        rf_waddr <= in_rd;
        rf_wdata <= in_alu_res;
        commit   <= 1'b1;
      end else if (w_resp) begin
        rf_waddr <= r_rd;
        commit   <= 1'b1;
        if (mem_rerr) begin
          ld_err <= 1'b1;
        end else begin
          rf_wen   <= r_rd_wen && (r_rd != '0);
          rf_wdata <= w_ld_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_wbu.sv
// Bench for the writeback unit: directed plan steps followed by randomized
// ALU/load traffic checked against a behavioural load-extraction model.
module tb_ysyx_25040111_wbu;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_res;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic        mem_rerr;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit;
  logic        ld_err;
  logic        dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  m_waddr;
  logic [31:0] m_wdata;

  ysyx_25040111_wbu dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_rd_wen  (in_rd_wen),
    .in_is_load (in_is_load),
    .in_funct3  (in_funct3),
    .in_addr_lo (in_addr_lo),
    .in_alu_res (in_alu_res),
    .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready),
    .mem_rdata  (mem_rdata),
    .mem_rerr   (mem_rerr),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .commit     (commit),
    .ld_err     (ld_err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: load result from funct3, byte offset and raw word.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (d >> (8 * a)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (d >> (16 * (a / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  // Driver tasks: inputs change at negedge, outputs checked at the following negedge.
  task automatic drive_alu(input logic [3:0] rd, input logic wen, input logic [31:0] res);
    in_valid   = 1'b1;
    in_is_load = 1'b0;
    in_rd      = rd;
    in_rd_wen  = wen;
    in_alu_res = res;
    in_funct3  = 3'($urandom);
    in_addr_lo = 2'($urandom);
    check("alu_in_ready", 32'(in_ready), 32'd1);
    m_waddr = rd;
    exp_q.push_back(res);
    @(negedge clock);
    m_wdata = exp_q.pop_front();
    check("alu_commit", 32'(commit), 32'd1);
    check("alu_rf_wen", 32'(rf_wen), 32'(wen && rd != 4'd0));
    check("alu_rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    check("alu_rf_wdata", rf_wdata, m_wdata);
    check("alu_ld_err", 32'(ld_err), 32'd0);
  endtask

  task automatic idle_cycle();
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    @(negedge clock);
    check("idle_commit", 32'(commit), 32'd0);
    check("idle_rf_wen", 32'(rf_wen), 32'd0);
    check("idle_ld_err", 32'(ld_err), 32'd0);
    check("idle_waddr_hold", 32'(rf_waddr), 32'(m_waddr));
    check("idle_wdata_hold", rf_wdata, m_wdata);
  endtask

  task automatic drive_load(input logic [3:0] rd, input logic wen, input logic [2:0] f3,
                            input logic [1:0] a, input logic [31:0] data, input logic err,
                            input int wait_n);
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd      = rd;
    in_rd_wen  = wen;
    in_funct3  = f3;
    in_addr_lo = a;
    in_alu_res = $urandom;
    check("ld_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    in_funct3  = 3'($urandom);
    in_addr_lo = 2'($urandom);
    check("ld_accept_commit", 32'(commit), 32'd0);
    check("ld_accept_rf_wen", 32'(rf_wen), 32'd0);
    check("ld_wait_in_ready", 32'(in_ready), 32'd0);
    check("ld_wait_mem_rready", 32'(mem_rready), 32'd1);
    check("ld_wait_state", 32'(dbg_state), 32'd1);
    for (int i = 0; i < wait_n; i++) begin
      mem_rdata = $urandom;
      mem_rerr  = 1'($urandom);
      @(negedge clock);
      check("ld_hold_commit", 32'(commit), 32'd0);
      check("ld_hold_mem_rready", 32'(mem_rready), 32'd1);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    mem_rerr   = err;
    m_waddr    = rd;
    if (!err) exp_q.push_back(ref_load(f3, a, data));
    else exp_q.push_back(m_wdata);
    @(negedge clock);
    mem_rvalid = 1'b0;
    mem_rerr   = 1'b0;
    m_wdata    = exp_q.pop_front();
    check("ld_commit", 32'(commit), 32'd1);
    check("ld_ld_err", 32'(ld_err), 32'(err));
    check("ld_rf_wen", 32'(rf_wen), 32'(!err && wen && rd != 4'd0));
    check("ld_rf_waddr", 32'(rf_waddr), 32'(m_waddr));
    check("ld_rf_wdata", rf_wdata, m_wdata);
    check("ld_done_in_ready", 32'(in_ready), 32'd1);
    check("ld_done_mem_rready", 32'(mem_rready), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_rd      = 4'd0;
    in_rd_wen  = 1'b0;
    in_is_load = 1'b0;
    in_funct3  = 3'd0;
    in_addr_lo = 2'd0;
    in_alu_res = 32'd0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    mem_rerr   = 1'b0;
    m_waddr    = 4'd0;
    m_wdata    = 32'd0;

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_rready", 32'(mem_rready), 32'd0);
    check("rst_rf_wen", 32'(rf_wen), 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_commit", 32'(commit), 32'd0);
    check("rst_ld_err", 32'(ld_err), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single ALU write
    drive_alu(4'd5, 1'b1, 32'h1234_5678);
    idle_cycle();

    // Back-to-back ALU writes, then rd=0
    drive_alu(4'd1, 1'b1, 32'hA);
    drive_alu(4'd2, 1'b1, 32'hB);
    drive_alu(4'd3, 1'b1, 32'hC);
    drive_alu(4'd0, 1'b1, 32'hDEAD_BEEF);
    drive_alu(4'd9, 1'b0, 32'h5555_AAAA);
    idle_cycle();

    // Directed loads
    drive_load(4'd7, 1'b1, 3'd0, 2'd3, 32'h80FF_1234, 1'b0, 4);
    check("lb_value", rf_wdata, 32'hFFFF_FF80);
    drive_load(4'd7, 1'b1, 3'd4, 2'd3, 32'h80FF_1234, 1'b0, 4);
    check("lbu_value", rf_wdata, 32'h0000_0080);
    drive_load(4'd8, 1'b1, 3'd1, 2'd2, 32'h8001_7FFF, 1'b0, 1);
    check("lh_value", rf_wdata, 32'hFFFF_8001);
    drive_load(4'd8, 1'b1, 3'd5, 2'd2, 32'h8001_7FFF, 1'b0, 0);
    check("lhu_value", rf_wdata, 32'h0000_8001);
    drive_load(4'd8, 1'b1, 3'd2, 2'd0, 32'h8001_7FFF, 1'b0, 2);
    check("lw_value", rf_wdata, 32'h8001_7FFF);
    drive_load(4'd0, 1'b1, 3'd2, 2'd0, 32'h1111_2222, 1'b0, 0);
    idle_cycle();

    // Faulted load
    drive_load(4'd6, 1'b1, 3'd2, 2'd0, 32'h9999_9999, 1'b1, 0);
    check("err_wdata_kept", rf_wdata, 32'h1111_2222);
    idle_cycle();

    // Reset in WAIT_MEM, late response ignored
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd      = 4'd4;
    in_rd_wen  = 1'b1;
    in_funct3  = 3'd2;
    @(negedge clock);
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    check("mid_wait_state", 32'(dbg_state), 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    m_waddr = 4'd0;
    m_wdata = 32'd0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_mem_rready", 32'(mem_rready), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_wdata", rf_wdata, 32'd0);
    @(negedge clock);
    reset_n    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(negedge clock);
    check("late_resp_commit", 32'(commit), 32'd0);
    check("late_resp_rf_wen", 32'(rf_wen), 32'd0);
    check("late_resp_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    check("idle_resp_commit", 32'(commit), 32'd0);
    check("idle_resp_wen", 32'(rf_wen), 32'd0);
    mem_rvalid = 1'b0;
    idle_cycle();

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        drive_alu(4'($urandom), 1'($urandom_range(0, 3) != 0), $urandom);
      end else begin
        drive_load(4'($urandom), 1'($urandom_range(0, 3) != 0), 3'($urandom),
                   2'($urandom), $urandom, $urandom_range(0, 7) == 0,
                   $urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25040111_wbu.md
Name: ysyx_25040111_wbu

Overview:
Writeback unit for the RV32E NPC core. It sits directly upstream of the 16-entry register file write port. It accepts retired-instruction results from the execute stage through a valid/ready handshake. For loads, it waits for the LSU read response, then extracts, aligns and extends the data. It drives a registered single-cycle write (wen/waddr/wdata) into the register file, plus a commit pulse used by trace/difftest.

Parameters:
XLEN, 32, data width of results and register file
RADDR_W, 4, register index width (16 architectural registers)

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  execute stage presents a retired instruction
in_ready  output  1  wbu can accept; high only in IDLE
in_rd  input  RADDR_W  destination register index
in_rd_wen  input  1  instruction writes rd
in_is_load  input  1  result comes from memory, not in_alu_res
in_funct3  input  3  load type (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
in_addr_lo  input  2  low bits of the load effective address
in_alu_res  input  XLEN  result for non-load instructions
mem_rvalid  input  1  LSU read response valid
mem_rready  output  1  wbu accepts response; high only in WAIT_MEM
mem_rdata  input  XLEN  raw aligned word from memory
mem_rerr  input  1  LSU response carries an access error
rf_wen  output  1  register file write enable (one-cycle pulse)
rf_waddr  output  RADDR_W  register file write index
rf_wdata  output  XLEN  register file write data
commit  output  1  one-cycle pulse per retired instruction
ld_err  output  1  one-cycle pulse alongside commit for a faulted load

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - rf_wen=0, rf_waddr=0, rf_wdata=0, commit=0, ld_err=0.
  - in_ready=0 while reset_n=0; in_ready=1 from the first cycle after release.
  - mem_rready=0.
- States and handshake:
  - IDLE: in_ready=1. Accept occurs on a clock edge with in_valid&&in_ready.
  - WAIT_MEM: in_ready=0, mem_rready=1.
- Non-load accept:
  - On the accept edge: rf_wen <= in_rd_wen && (in_rd!=0); rf_waddr <= in_rd; rf_wdata <= in_alu_res; commit <= 1.
  - State stays IDLE. Back-to-back accepts give one write per cycle.
  - Latency: the write is visible on the outputs the cycle after accept.
- Load accept:
  - Latch rd, rd_wen, funct3 and addr_lo.
  - commit/rf_wen <= 0; state <= WAIT_MEM.
- WAIT_MEM:
  - Hold until mem_rvalid=1; the response is consumed on that edge.
  - Then rf_waddr <= latched rd; commit <= 1; state <= IDLE.
  - If mem_rerr=0: rf_wen <= rd_wen && (rd!=0); rf_wdata <= extracted value.
  - If mem_rerr=1: rf_wen <= 0; ld_err <= 1; rf_wdata unchanged.
- Outputs when nothing commits: rf_wen, commit and ld_err return to 0 on every edge without a commit. rf_waddr and rf_wdata hold their last value.
- Load extraction:
  - b = mem_rdata >> (8*addr_lo).
  - lb: sign-extend b[7:0]; lbu: zero-extend b[7:0].
  - lh: sign-extend the half selected by addr_lo[1]; lhu: zero-extend it. addr_lo[0] is ignored for halves.
  - lw and any other funct3: full mem_rdata; addr_lo is ignored.
- rd=0: never asserts rf_wen; commit still pulses.
- mem_rvalid in IDLE: ignored, since mem_rready=0.
- Reset mid-load: returns to IDLE. A response arriving after reset release is ignored and the load never commits.
- Registers written by a load are not forwarded by this block. The register file's own write-through forwarding covers same-cycle reads.

Test Plan:
1. Reset, then ALU accept in_rd=5, in_rd_wen=1, in_alu_res=0x1234_5678 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x12345678, commit=1; the following cycle rf_wen=0.
2. Three back-to-back ALU accepts to x1, x2, x3 (values 0xA, 0xB, 0xC) -> in_ready stays 1; three consecutive write pulses in order; in_rd=0 case -> commit=1, rf_wen=0.
3. lb, addr_lo=3, rd=7; mem_rvalid after 4 cycles with mem_rdata=0x80FF_1234 -> in_ready=0 and mem_rready=1 while waiting; then rf_wdata=0xFFFF_FF80, rf_waddr=7, commit=1. Repeat as lbu -> 0x0000_0080.
4. lh, addr_lo=2 with mem_rdata=0x8001_7FFF -> 0xFFFF_8001; lhu -> 0x0000_8001; lw addr_lo=0 -> 0x8001_7FFF.
5. Load with mem_rvalid=1 and mem_rerr=1 -> commit=1, ld_err=1, rf_wen=0.
6. reset_n pulsed low in WAIT_MEM, then mem_rvalid=1 -> no commit, no rf_wen; in_ready=1 after release; mem_rvalid in IDLE produces nothing.
